// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM address/data, decode back-pressure,
// branch/jump redirect and the IF/ID register outputs.
// With FETCH_PERF_EN defined the bundle also carries the perf counters.
interface instr_fetch_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_data;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_pc_plus4;
    logic            fetch_fault;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_bubbles;
`endif

    // Fetch unit side
    modport master (
`ifdef FETCH_PERF_EN
        output perf_fetched,
        output perf_bubbles,
`endif
        output rom_addr,
        input  rom_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output id_valid,
        output id_instr,
        output id_pc,
        output id_pc_plus4,
        output fetch_fault
    );

    // ROM / decode / branch-unit side
    modport slave (
`ifdef FETCH_PERF_EN
        input  perf_fetched,
        input  perf_bubbles,
`endif
        input  rom_addr,
        output rom_data,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4,
        input  fetch_fault
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, ROM addressing and the IF/ID
// pipeline register, with decode stall, redirect/flush and a sticky halt on
// a misaligned redirect target.
// Optional feature macro: FETCH_PERF_EN (adds perf_fetched/perf_bubbles).
module instr_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);

    // A misaligned reset vector cannot be fetched; flag it at elaboration.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("instr_fetch: RESET_PC must be 4-byte aligned");
    end

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic            fetch_fault_q, fetch_fault_d;
    logic            misaligned_s;

    // Next-state logic: redirect beats stall, stall beats capture; HALT freezes.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fetch_fault_d = fetch_fault_q;
        misaligned_s  = (bus.redirect_pc[1:0] != 2'b00);

        case (state_q)
            ST_BOOT, ST_RUN: begin
                if (bus.redirect_valid && misaligned_s) begin
                    state_d       = ST_HALT;
                    fetch_fault_d = 1'b1;
                    id_valid_d    = 1'b0;
                end else if (bus.redirect_valid) begin
                    state_d    = ST_RUN;
                    pc_d       = bus.redirect_pc;
                    id_valid_d = 1'b0;
                end else if (state_q == ST_BOOT) begin
                    // The ROM word at RESET_PC is fetched on the following edge.
                    state_d    = ST_RUN;
                    id_valid_d = 1'b0;
                end else if (bus.stall) begin
                    state_d = ST_RUN;
                end else begin
                    state_d       = ST_RUN;
                    id_instr_d    = bus.rom_data;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_q + PC_STEP;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_q + PC_STEP;
                end
            end
            ST_HALT: begin
                state_d       = ST_HALT;
                id_valid_d    = 1'b0;
                fetch_fault_d = 1'b1;
            end
            default: begin
                state_d       = ST_HALT;
                id_valid_d    = 1'b0;
                fetch_fault_d = 1'b1;
            end
        endcase
    end

    // FSM state, PC and IF/ID pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.fetch_fault = fetch_fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;
    logic        active_s;
    logic        capture_s;

    // Perf counters: captures, and cycles that leave IF/ID empty; frozen in HALT.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        active_s       = (state_q == ST_BOOT) || (state_q == ST_RUN);
        capture_s      = (state_q == ST_RUN) && !bus.redirect_valid && !bus.stall;
        if (active_s) begin
            if (capture_s) begin
                perf_fetched_d = perf_fetched_q + 32'd1;
            end else begin
                perf_fetched_d = perf_fetched_q;
            end
            if (!id_valid_d) begin
                perf_bubbles_d = perf_bubbles_q + 32'd1;
            end else begin
                perf_bubbles_d = perf_bubbles_q;
            end
        end else begin
            perf_fetched_d = perf_fetched_q;
            perf_bubbles_d = perf_bubbles_q;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a behavioural fetch model compared on
// every cycle, plus directed vectors with literal expected values.
module tb_instr_fetch;

    logic clk;
    logic rst_n;
    logic chk_en;
    int   checks;
    int   errors;

    instr_fetch_if #(.XLEN(32)) ifc ();

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    // Bench ROM: word 3 is a fixed instruction, others encode their address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'd12) return 32'h0000_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign ifc.rom_data = rom_word(ifc.rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_fetched, m_bubbles;
    logic        m_boot, m_halt, m_valid, m_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_boot = 1'b1; m_halt = 1'b0; m_valid = 1'b0;
        m_instr = 32'h0000_0013; m_idpc = 32'd0; m_idpc4 = 32'd0; m_fault = 1'b0;
        m_fetched = 32'd0; m_bubbles = 32'd0;
    endtask

    task automatic model_step();
        if (m_halt) return;
        if (ifc.redirect_valid && (ifc.redirect_pc % 32'd4 != 32'd0)) begin
            m_halt = 1'b1; m_fault = 1'b1; m_valid = 1'b0;
        end else if (ifc.redirect_valid) begin
            m_pc = ifc.redirect_pc; m_valid = 1'b0;
        end else if (m_boot || ifc.stall) begin
            // nothing captured, pc held
        end else begin
            m_instr = rom_word(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4; m_fetched = m_fetched + 32'd1;
        end
        if (!m_valid) m_bubbles = m_bubbles + 32'd1;
        m_boot = 1'b0;
    endtask

    task automatic compare_all();
        chk("m_rom_addr", ifc.rom_addr, m_pc);
        chk("m_id_valid", 32'(ifc.id_valid), 32'(m_valid));
        chk("m_id_instr", ifc.id_instr, m_instr);
        chk("m_id_pc", ifc.id_pc, m_idpc);
        chk("m_id_pc_plus4", ifc.id_pc_plus4, m_idpc4);
        chk("m_fetch_fault", 32'(ifc.fetch_fault), 32'(m_fault));
`ifdef FETCH_PERF_EN
        chk("m_perf_fetched", ifc.perf_fetched, m_fetched);
        chk("m_perf_bubbles", ifc.perf_bubbles, m_bubbles);
`endif
    endtask

    // Compare process: advance the model on each edge, then check the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
        #2;
        if (chk_en) compare_all();
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_rom_addr"}, ifc.rom_addr, 32'd0);
        chk({tag, "_id_valid"}, 32'(ifc.id_valid), 32'd0);
        chk({tag, "_id_instr"}, ifc.id_instr, 32'h0000_0013);
        chk({tag, "_id_pc"}, ifc.id_pc, 32'd0);
        chk({tag, "_id_pc_plus4"}, ifc.id_pc_plus4, 32'd0);
        chk({tag, "_fault"}, 32'(ifc.fetch_fault), 32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, "_perf_fetched"}, ifc.perf_fetched, 32'd0);
        chk({tag, "_perf_bubbles"}, ifc.perf_bubbles, 32'd0);
`endif
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        rst_n = 1'b0;
        ifc.stall = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_pc = 32'd0;
        #12;
        chk_reset("por");
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // Boot and sequential fetch
        tick(); chk("boot_addr", ifc.rom_addr, 32'd0); chk("boot_valid", 32'(ifc.id_valid), 32'd0);
        tick(); chk("f0_addr", ifc.rom_addr, 32'd4); chk("f0_pc", ifc.id_pc, 32'd0);
                chk("f0_instr", ifc.id_instr, 32'h5A5A_0000);
        tick(); chk("f1_addr", ifc.rom_addr, 32'd8);
        tick(); chk("f2_addr", ifc.rom_addr, 32'd12);
        tick(); chk("f3_pc", ifc.id_pc, 32'd12); chk("f3_instr", ifc.id_instr, 32'h0000_0093);
                chk("f3_plus4", ifc.id_pc_plus4, 32'd16);
        tick(); chk("f4_pc", ifc.id_pc, 32'd16); chk("f4_addr", ifc.rom_addr, 32'd20);

        // Three stall cycles
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", ifc.rom_addr, 32'd20);
            chk("stall_pc", ifc.id_pc, 32'd16);
            chk("stall_valid", 32'(ifc.id_valid), 32'd1);
        end
        ifc.stall = 1'b0;
        tick(); chk("unstall_pc", ifc.id_pc, 32'd20); chk("unstall_addr", ifc.rom_addr, 32'd24);
        tick(); chk("f6_addr", ifc.rom_addr, 32'd28);

        // Redirect together with stall: redirect wins, one bubble
        ifc.stall = 1'b1; ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h0000_0018;
        tick(); chk("redir_valid", 32'(ifc.id_valid), 32'd0); chk("redir_addr", ifc.rom_addr, 32'd24);
        ifc.stall = 1'b0; ifc.redirect_valid = 1'b0;
        tick(); chk("redir_pc", ifc.id_pc, 32'd24); chk("redir_valid2", 32'(ifc.id_valid), 32'd1);

        // Wrap-around at the top of the address space
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'hFFFF_FFFC;
        tick(); chk("wrap_addr", ifc.rom_addr, 32'hFFFF_FFFC);
        ifc.redirect_valid = 1'b0;
        tick(); chk("wrap_pc", ifc.id_pc, 32'hFFFF_FFFC); chk("wrap_plus4", ifc.id_pc_plus4, 32'd0);
                chk("wrap_next", ifc.rom_addr, 32'd0); chk("wrap_fault", 32'(ifc.fetch_fault), 32'd0);
        tick(); tick();

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1 chk_reset("async");
        #1 rst_n = 1'b1;

        // Perf run: BOOT, 5 fetches, 1 redirect
        tick();
        for (int i = 0; i < 5; i++) tick();
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h0000_0040;
        tick();
        ifc.redirect_valid = 1'b0;
        chk("perf_redir_addr", ifc.rom_addr, 32'h0000_0040);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", ifc.perf_fetched, 32'd5);
        chk("perf_bubbles", ifc.perf_bubbles, 32'd2);
`endif
        tick(); chk("f40_instr", ifc.id_instr, 32'h5A5A_0040);

        // Misaligned redirect: halt with sticky fault
        ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h0000_0022;
        tick();
        ifc.redirect_valid = 1'b0;
        chk("halt_fault", 32'(ifc.fetch_fault), 32'd1);
        chk("halt_valid", 32'(ifc.id_valid), 32'd0);
        chk("halt_addr", ifc.rom_addr, 32'h0000_0044);
        for (int i = 0; i < 10; i++) begin
            ifc.stall = i[0];
            ifc.redirect_valid = i[1];
            ifc.redirect_pc = 32'h0000_0100 + 32'(i) * 32'd4;
            tick();
            chk("halt_hold_addr", ifc.rom_addr, 32'h0000_0044);
            chk("halt_hold_fault", 32'(ifc.fetch_fault), 32'd1);
            chk("halt_hold_valid", 32'(ifc.id_valid), 32'd0);
        end
        ifc.stall = 1'b0; ifc.redirect_valid = 1'b0;

        // Reset pulse leaves HALT and restarts at RESET_PC
        #2 rst_n = 1'b0;
        #1 chk_reset("halt_rst");
        #1 rst_n = 1'b1;
        tick(); chk("restart_boot", ifc.rom_addr, 32'd0);
        tick(); chk("restart_addr", ifc.rom_addr, 32'd4); chk("restart_pc", ifc.id_pc, 32'd0);
                chk("restart_valid", 32'(ifc.id_valid), 32'd1);

        chk_en = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the combinational instruction ROM. It holds the program counter and drives the ROM word address. It captures the returned instruction into an IF/ID pipeline register for decode. It also supports decode stalls, branch/jump redirects with flush, and halts on a misaligned redirect target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
XLEN, 32, width of PC, address and instruction buses.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
rom_addr  output  XLEN  byte address to ROM, equal to current PC (ROM uses bits [31:2])
rom_data  input  XLEN  instruction word from ROM, valid combinationally in the same cycle
stall  input  1  decode not ready; hold PC and IF/ID register
redirect_valid  input  1  branch/jump taken; load redirect_pc
redirect_pc  input  XLEN  redirect target byte address
id_valid  output  1  IF/ID register holds a valid instruction
id_instr  output  XLEN  registered instruction
id_pc  output  XLEN  PC of id_instr
id_pc_plus4  output  XLEN  id_pc + 4 (mod 2^XLEN)
fetch_fault  output  1  sticky misaligned-redirect fault

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- States: BOOT, RUN, HALT. State is encoded in 2 bits; the unused encoding returns to HALT.
- Reset values:
  - state=BOOT, pc=RESET_PC.
  - id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, id_pc_plus4=0.
  - fetch_fault=0.
- rom_addr = pc at all times, purely combinational from the pc register.
- BOOT: lasts one cycle after reset deassertion.
  - No capture; id_valid stays 0. pc unchanged.
  - Next state is RUN, unless redirect_valid is high, in which case the RUN redirect rules apply.
- RUN, priority order per edge:
  1. redirect_valid=1 and redirect_pc[1:0]!=0:
     - state becomes HALT, fetch_fault becomes 1, id_valid becomes 0, pc holds.
  2. redirect_valid=1 and redirect_pc is aligned:
     - pc becomes redirect_pc, id_valid becomes 0 (flush).
     - Stall is ignored: the redirect overrides it.
  3. stall=1:
     - pc, id_valid, id_instr, id_pc and id_pc_plus4 all hold.
  4. Otherwise:
     - id_instr becomes rom_data, id_pc becomes pc, id_pc_plus4 becomes pc+4, id_valid becomes 1.
     - pc becomes pc+4.
- Fetch latency: an instruction appears on id_* exactly one edge after its address is on rom_addr. After a redirect there is exactly one bubble cycle.
- Arithmetic: pc+4 wraps modulo 2^XLEN, so 32'hFFFF_FFFC is followed by 32'h0000_0000 with no fault.
- HALT:
  - All registers hold; id_valid=0; fetch_fault=1.
  - Inputs are ignored. Only rst_n exits HALT.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously), independent of clk.
- RESET_PC misaligned is a configuration error. A simulation-only check fires at time 0.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0], both reset to 0.
  - perf_fetched increments on every RUN capture (case 4).
  - perf_bubbles increments on every cycle in RUN or BOOT where id_valid is 0 on the next edge.
  - Both counters wrap at 2^32 and freeze in HALT.
- Undefined: the ports and counters do not exist and there is no logic overhead.

Test Plan:
- Reset release, RESET_PC=0, ROM word3=32'h0000_0093, no stall/redirect:
  - rom_addr reads 0,0(BOOT),4,8,12 on successive cycles.
  - id_pc=12 arrives with id_instr=32'h0000_0093 and id_pc_plus4=16.
- Stall held 3 cycles while id_pc=16:
  - rom_addr stays 20; id_* unchanged, id_valid=1.
  - After release, the next capture gives id_pc=20.
- Redirect to 32'h0000_0018 asserted together with stall=1:
  - Next cycle: id_valid=0, rom_addr=24.
  - Following cycle: id_pc=24, id_valid=1.
- Redirect to 32'h0000_0022:
  - fetch_fault=1, id_valid=0, rom_addr frozen.
  - Remains frozen for 10 cycles regardless of inputs.
  - Pulsing rst_n low clears it and fetch restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC:
  - Captures id_pc=32'hFFFF_FFFC, id_pc_plus4=0.
  - Next rom_addr=0, fetch_fault=0.
- rst_n asserted between clock edges mid-run:
  - Outputs go to reset values before the next clk edge.
  - With FETCH_PERF_EN, counters read 0 afterwards.
  - Perf check over 5 plain fetches plus 1 redirect: perf_fetched=5, perf_bubbles=2 (BOOT + flush).
